// File: rtl/reg_onehot_decoder.sv
// 5-to-32 one-hot decoder with a combinational output and a registered copy
// (decode, select index and valid flag) for pipelined consumers.
module reg_onehot_decoder #(
    parameter int SEL_W = 5,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [SEL_W-1:0] Sel,
    output logic [OUT_W-1:0] Output,
    output logic [OUT_W-1:0] out_q,
    output logic [SEL_W-1:0] idx_q,
    output logic             valid_q
);

    // Every code is legal, so the decode never produces an all-zero word.
    always_comb begin
        Output      = '0;
        Output[Sel] = 1'b1;
    end

    // Reset wins over en; the registered decode reuses the combinational one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (en) begin
            out_q   <= Output;
            idx_q   <= Sel;
            valid_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_onehot_decoder.sv
// Directed and random stimulus for reg_onehot_decoder; expected decode and
// register state are queued when driven and compared at the following negedge.
module tb_reg_onehot_decoder;

    logic        clk;
    logic        reset;
    logic        en;
    logic [4:0]  sel;
    logic [31:0] out_comb;
    logic [31:0] out_q;
    logic [4:0]  idx_q;
    logic        valid_q;

    reg_onehot_decoder #(.SEL_W(5), .OUT_W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .Sel     (sel),
        .Output  (out_comb),
        .out_q   (out_q),
        .idx_q   (idx_q),
        .valid_q (valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] comb;
        logic [31:0] q;
        logic [4:0]  idx;
        logic        v;
    } exp_t;

    exp_t q_exp[$];

    int errors = 0;
    int checks = 0;

    // Reference register state and the inputs it will capture at the next edge
    logic [31:0] m_q   = '0;
    logic [4:0]  m_idx = '0;
    logic        m_v   = 1'b0;
    logic        p_rst = 1'b0;
    logic        p_en  = 1'b0;
    logic [4:0]  p_sel = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One cycle: advance the model over the edge, drive new inputs 1 ns later,
    // then compare everything at the negedge.
    task automatic step(input logic r, input logic e, input logic [4:0] s, input string tag);
        exp_t x;
        exp_t y;
        @(posedge clk);
        if (!p_rst) begin
            m_q = '0; m_idx = '0; m_v = 1'b0;
        end else if (p_en) begin
            m_q = 32'd1 << p_sel; m_idx = p_sel; m_v = 1'b1;
        end
        #1;
        reset = r; en = e; sel = s;
        p_rst = r; p_en = e; p_sel = s;
        x.comb = 32'd1 << s; x.q = m_q; x.idx = m_idx; x.v = m_v;
        q_exp.push_back(x);
        @(negedge clk);
        y = q_exp.pop_front();
        chk({tag, ".Output"},  out_comb,          y.comb);
        chk({tag, ".out_q"},   out_q,             y.q);
        chk({tag, ".idx_q"},   {27'd0, idx_q},    {27'd0, y.idx});
        chk({tag, ".valid_q"}, {31'd0, valid_q},  {31'd0, y.v});
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; sel = '0;

        // Reset held for two edges with en=1, Sel=7
        step(1'b0, 1'b1, 5'd7, "rst0");
        step(1'b0, 1'b1, 5'd7, "rst1");
        chk("rst.out_q_zero", out_q, 32'h0);
        chk("rst.Output7", out_comb, 32'h0000_0080);

        // Release and capture 3, then hold while Sel moves to 30
        step(1'b1, 1'b1, 5'd3, "cap3");
        step(1'b1, 1'b0, 5'd30, "hold30");
        chk("hold.out_q", out_q, 32'h0000_0008);
        chk("hold.Output30", out_comb, 32'h4000_0000);
        step(1'b1, 1'b0, 5'd30, "hold30b");
        chk("hold.idx_q", {27'd0, idx_q}, 32'd3);

        // Full sweep with back-to-back captures
        for (int s = 0; s < 32; s++) begin
            step(1'b1, 1'b1, 5'(s), "sweep");
            case (s)
                0:  chk("spot0",  out_comb, 32'h0000_0001);
                5:  chk("spot5",  out_comb, 32'h0000_0020);
                16: chk("spot16", out_comb, 32'h0001_0000);
                31: chk("spot31", out_comb, 32'h8000_0000);
                default: ;
            endcase
        end

        // Capture 12, then reset mid-operation with en still high
        step(1'b1, 1'b1, 5'd12, "cap12");
        step(1'b0, 1'b1, 5'd12, "midrst");
        chk("midrst.out_q12", out_q, 32'h0000_1000);
        step(1'b1, 1'b0, 5'd9, "postrst");
        chk("postrst.valid_q", {31'd0, valid_q}, 32'd0);

        // Random select and enable
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), "rand");
            chk("rand.onehot", {31'd0, $onehot(out_comb)}, 32'd1);
            if (m_v)
                chk("rand.qidx", {31'd0, out_q[idx_q]}, 32'd1);
        end
        step(1'b1, 1'b0, 5'd0, "flush");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_onehot_decoder.md
Name: reg_onehot_decoder

Overview:
- 5-to-32 one-hot decoder for MIPS register-file write-select and similar select fan-out.
- Provides a combinational one-hot output, `Output`, plus a registered copy with a valid flag for pipelined consumers.
- `Output` is a pure function of `Sel`.
- The registered path is clocked by `clk` with synchronous active-low reset.

Parameters:
- SEL_W, 5, select width in bits.
- OUT_W, 32, output width; must equal 2**SEL_W.

Ports:
- clk  input  1  clock; all registers update on its rising edge.
- reset  input  1  synchronous, active-low reset.
- en  input  1  capture enable for the registered path; does not affect `Output`.
- Sel  input  SEL_W  binary select index.
- Output  output  OUT_W  combinational one-hot decode of `Sel`.
- out_q  output  OUT_W  registered one-hot decode.
- idx_q  output  SEL_W  registered copy of `Sel` captured with `out_q`.
- valid_q  output  1  `out_q` and `idx_q` hold a captured value.

Behaviour:
Combinational path (`Output`):
- `Output[i]` = 1 iff i == `Sel`; all other bits 0.
- Exactly one bit is high for every legal `Sel` (0..31).
- `Output` is independent of `clk`, `reset` and `en`.
- Zero-latency: `Output` must settle within the same cycle `Sel` changes.
- The bench drives `Sel` 1 ns after posedge and samples at negedge.
- `Output` = 32'h0000_0001 for `Sel`=0 and 32'h8000_0000 for `Sel`=31.
- No reserved or invalid codes; all 32 codes decode.
- If `Sel` contains X/Z, `Output` is don't-care; the bench masks those bits.

Registered path, at each rising edge of `clk`:
- If `reset`==0: `out_q`<=0, `idx_q`<=0, `valid_q`<=0. Reset has priority over `en`.
- Else if `en`==1: `out_q`<=one-hot(`Sel`), `idx_q`<=`Sel`, `valid_q`<=1.
- Else: all registers hold their values.

Registered-path rules:
- Latency from `Sel` to `out_q` is 1 cycle.
- Back-to-back captures are allowed every cycle.
- While `valid_q`==1, `out_q` is always exactly one-hot and `out_q`[`idx_q`]==1.
- `reset` asserted mid-operation clears the registers at that edge regardless of `en`/`Sel`.
- `Output` keeps decoding `Sel` during reset.
- Reset values: `out_q`=0, `idx_q`=0, `valid_q`=0. `Output` has no reset value (combinational).
- No internal state beyond the three registers; no handshake back-pressure.

Test Plan:
- Sweep `Sel`=0..31 with `reset` deasserted; at each negedge `Output` must equal 1<<`Sel`. Spot values: 0->0x00000001, 5->0x00000020, 16->0x00010000, 31->0x80000000. Zero mismatches over 32 vectors.
- Hold `reset`=0 for 2 edges with `en`=1 and `Sel`=7 -> `out_q`=0, `idx_q`=0, `valid_q`=0. Meanwhile `Output`=0x00000080.
- Release reset, `en`=1, `Sel`=3 -> after next posedge `out_q`=0x00000008, `idx_q`=3, `valid_q`=1.
- Drop `en`=0, change `Sel` to 30 -> `out_q` holds 0x00000008 and `idx_q` holds 3; `Output` immediately becomes 0x40000000.
- Capture `Sel`=12 then assert `reset`=0 on the following edge with `en`=1 -> registers clear that edge; `valid_q`=0.
- Random 1000 `Sel` values with random `en` -> `Output` is always one-hot and equal to 1<<`Sel`. `out_q` equals one-hot(`Sel` at last enabled edge), and `valid_q` holds at 1 after the first capture.
